// File: rtl/palt_nios_sys_nios_oci_dct_ctrl.sv
// Nios OCI data-capture-trace packing sequencer.
// Packs 3-bit trace frames into a 30-bit word, hands full (or timed-out /
// flushed partial) words to trace memory through one valid/ready holding
// register, and runs the end-of-test flush.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal capture; frames accepted, timeout flush active
// ST_DRAIN | end-of-test flush; no accepts, push out partial word
// ST_DONE  | flush complete; test_has_ended held until reset
module palt_nios_sys_nios_oci_dct_ctrl #(
  parameter int FRAME_W       = 3,
  parameter int DEPTH         = 10,
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         trc_en,
  input  logic                         trc_valid,
  input  logic [FRAME_W-1:0]           trc_frame,
  output logic                         trc_ready,
  input  logic                         flush_req,
  output logic                         tw_valid,
  output logic [4+FRAME_W*DEPTH-1:0]   tw_data,
  input  logic                         tw_ready,
  output logic [FRAME_W*DEPTH-1:0]     dct_buffer,
  output logic [3:0]                   dct_count,
  output logic                         test_ending,
  output logic                         test_has_ended
);

  localparam int CNT_W = 4;
  localparam int TO_W  = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [TO_W-1:0]  to_cnt;
  logic             full;
  logic             slot_free;
  logic             to_hit;
  logic             accept;
  logic             handoff;
  logic [CNT_W-1:0] wr_slot;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Next state, handshake decode and status outputs.
  always_comb begin
    state_d        = state_q;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    full      = (dct_count == CNT_W'(DEPTH));
    // The holding register can take a new word if empty or emptying this cycle,
    // which is what lets consecutive hand-offs go out back to back.
    slot_free = !tw_valid || tw_ready;
    to_hit    = (FLUSH_TIMEOUT != 0) && (to_cnt == TO_W'(FLUSH_TIMEOUT));
    trc_ready = trc_en && (state_q == ST_RUN) && !(full && tw_valid);
    accept    = trc_valid && trc_ready;
    handoff   = slot_free &&
                (full || ((dct_count != '0) && (to_hit || (state_q == ST_DRAIN))));
    // A frame arriving with a hand-off lands in slot 0 of the emptied buffer.
    wr_slot   = handoff ? '0 : dct_count;
    case (state_q)
      ST_RUN: begin
        if (flush_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        test_ending = 1'b1;
        if ((dct_count == '0) && !tw_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        test_has_ended = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Packing buffer and occupancy; stale slots are left for the consumer to mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (accept && (wr_slot == CNT_W'(k)))
          dct_buffer[k*FRAME_W +: FRAME_W] <= trc_frame;
      end
      dct_count <= wr_slot + CNT_W'(accept);
    end
  end

  // Output holding register towards trace memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tw_valid <= 1'b0;
      tw_data  <= '0;
    end else if (handoff) begin
      tw_valid <= 1'b1;
      tw_data  <= {dct_count, dct_buffer};
    end else if (tw_ready) begin
      tw_valid <= 1'b0;
    end
  end

  // Idle timer for partially filled buffers; saturates at the flush threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (accept || handoff) begin
      to_cnt <= '0;
    end else if ((FLUSH_TIMEOUT != 0) && (state_q == ST_RUN) &&
                 (dct_count != '0) && !full && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_palt_nios_sys_nios_oci_dct_ctrl.sv
// Bench for the DCT packing sequencer. The reference model is the ordered
// stream of accepted frames: every word written to trace memory must consume
// the next `count` frames of that stream, in slot order.
module tb_palt_nios_sys_nios_oci_dct_ctrl;

  logic        clk;
  logic        reset_n;
  logic        trc_en;
  logic        trc_valid;
  logic [2:0]  trc_frame;
  logic        trc_ready;
  logic        flush_req;
  logic        tw_valid;
  logic [33:0] tw_data;
  logic        tw_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  palt_nios_sys_nios_oci_dct_ctrl #(
    .FRAME_W(3), .DEPTH(10), .FLUSH_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trc_en(trc_en), .trc_valid(trc_valid),
    .trc_frame(trc_frame), .trc_ready(trc_ready), .flush_req(flush_req),
    .tw_valid(tw_valid), .tw_data(tw_data), .tw_ready(tw_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_wr  = 0;
  logic [2:0]  acc_q[$];
  logic [33:0] last_word;
  logic        hold_pend;
  logic [33:0] hold_data;
  logic        last_accept;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_word(input logic [33:0] w);
    int cnt;
    logic [2:0] e;
    cnt = int'(w[33:30]);
    chk_eq("wr_cnt_range", (cnt >= 1 && cnt <= 10), 1);
    for (int i = 0; i < cnt && i < 10; i++) begin
      if (acc_q.size() == 0) chk_eq("wr_frame_underflow", 1, 0);
      else begin
        e = acc_q.pop_front();
        chk_eq("wr_frame", w[3*i +: 3], e);
      end
    end
  endtask

  // One clock: drive at negedge, observe handshakes 2 ns before the rising edge.
  task automatic cyc(input logic v, input logic [2:0] f, input logic en,
                     input logic rdy, input logic fl);
    @(negedge clk);
    trc_valid = v; trc_frame = f; trc_en = en; tw_ready = rdy; flush_req = fl;
    #3;
    last_accept = trc_valid && trc_ready;
    if (last_accept) begin
      acc_q.push_back(trc_frame);
      n_acc++;
    end
    if (hold_pend) begin
      chk_eq("hold_valid", tw_valid, 1);
      chk_eq("hold_data", tw_data, hold_data);
    end
    if (tw_valid && tw_ready) begin
      check_word(tw_data);
      n_wr++;
      last_word = tw_data;
    end
    hold_pend = tw_valid && !tw_ready;
    hold_data = tw_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    trc_valid = 0; trc_en = 1; tw_ready = 1; flush_req = 0; trc_frame = 0;
    acc_q.delete();
    hold_pend = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((acc_q.size() != 0 || tw_valid || dct_count != 0) && k < 60) begin
      cyc(0, 0, 1, 1, 0);
      k++;
    end
    chk_eq({tag, "_drain_done"}, (k < 60), 1);
    chk_eq({tag, "_model_empty"}, acc_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0, drops, hit;
    reset_n = 0; trc_valid = 0; trc_en = 1; tw_ready = 1; flush_req = 0; trc_frame = 0;
    hold_pend = 0; last_word = '0; hold_data = '0; last_accept = 0;
    do_reset();
    #1;
    chk_eq("rst_tw_valid", tw_valid, 0);
    chk_eq("rst_tw_data", tw_data, 0);
    chk_eq("rst_count", dct_count, 0);
    chk_eq("rst_buffer", dct_buffer, 0);
    chk_eq("rst_test_ending", test_ending, 0);
    chk_eq("rst_test_has_ended", test_has_ended, 0);
    chk_eq("rst_trc_ready", trc_ready, 1);

    // Single full word 0..7,0,1.
    w0 = n_wr;
    for (int i = 0; i < 10; i++) cyc(1, 3'(i % 8), 1, 1, 0);
    repeat (3) cyc(0, 0, 1, 1, 0);
    chk_eq("full_nwr", n_wr - w0, 1);
    chk_eq("full_word", last_word, {4'd10, 30'o1076543210});
    chk_eq("full_count0", dct_count, 0);

    // 25 back-to-back frames: no bubbles.
    w0 = n_wr; drops = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1, 3'($urandom_range(0, 7)), 1, 1, 0);
      if (!last_accept) drops++;
    end
    chk_eq("stream_ready_drops", drops, 0);
    chk_eq("stream_nwr", n_wr - w0, 2);
    cyc(0, 0, 1, 1, 0);
    chk_eq("stream_count5", dct_count, 5);
    drain("stream");
    chk_eq("stream_partial_cnt", last_word[33:30], 5);

    // Backpressure: 25 frames offered with memory stalled.
    a0 = n_acc;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 30; c++) begin
        cyc(sent < 25, 3'($urandom_range(0, 7)), 1, 0, 0);
        if (last_accept) sent++;
      end
      chk_eq("bp_accepts", n_acc - a0, 20);
      chk_eq("bp_count10", dct_count, 10);
      chk_eq("bp_trc_ready", trc_ready, 0);
      chk_eq("bp_tw_valid", tw_valid, 1);
      for (int c = 0; c < 40 && sent < 25; c++) begin
        cyc(1, 3'($urandom_range(0, 7)), 1, 1, 0);
        if (last_accept) sent++;
      end
      chk_eq("bp_all_sent", sent, 25);
    end
    drain("bp");

    // Timeout flush of a 3-frame partial word.
    for (int i = 0; i < 3; i++) cyc(1, 3'(i + 5), 1, 1, 0);
    w0 = n_wr; hit = -1;
    for (int j = 0; j < 12; j++) begin
      cyc(0, 0, 1, 1, 0);
      if (hit < 0 && n_wr != w0) hit = j;
    end
    chk_eq("to_window", (hit >= 4 && hit <= 8), 1);
    chk_eq("to_cnt3", last_word[33:30], 3);
    chk_eq("to_count0", dct_count, 0);

    // Randomised traffic against the stream model.
    for (int c = 0; c < 400; c++)
      cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
          $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, 0);
    drain("rand");

    // End-of-test flush with a frame arriving alongside flush_req.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 3'(7 - i), 1, 1, 0);
    cyc(1, 3'd2, 1, 1, 1);
    chk_eq("fl_last_accept", last_accept, 1);
    a0 = n_acc; w0 = n_wr;
    cyc(1, 3'd4, 1, 1, 0);
    chk_eq("fl_test_ending", test_ending, 1);
    for (int c = 0; c < 30 && !test_has_ended; c++) cyc(1, 3'd4, 1, 1, 0);
    chk_eq("fl_has_ended", test_has_ended, 1);
    chk_eq("fl_ending_off", test_ending, 0);
    chk_eq("fl_nwr", n_wr - w0, 1);
    chk_eq("fl_word_cnt", last_word[33:30], 8);
    chk_eq("fl_no_accept", n_acc - a0, 0);
    repeat (3) cyc(1, 3'd1, 1, 1, 1);
    chk_eq("fl_sticky", test_has_ended, 1);
    chk_eq("fl_no_accept2", n_acc - a0, 0);

    // Asynchronous reset while a word is pending and a flush is running.
    do_reset();
    for (int i = 0; i < 13; i++) cyc(1, 3'(i % 8), 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    chk_eq("ar_pre_valid", tw_valid, 1);
    chk_eq("ar_pre_ending", test_ending, 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk_eq("ar_tw_valid", tw_valid, 0);
    chk_eq("ar_count", dct_count, 0);
    chk_eq("ar_test_ending", test_ending, 0);
    chk_eq("ar_test_has_ended", test_has_ended, 0);
    chk_eq("ar_buffer", dct_buffer, 0);
    acc_q.delete();
    hold_pend = 0;
    @(negedge clk);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
